// File: rtl/count_ctrl.sv
// Run/pause/clear controller for the decimal counter chain: debounced buttons,
// a prescaled count-enable tick and a one-cycle synchronous clear.

module count_ctrl_db #(
  parameter int DB_LEN = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int DBW = $clog2(DB_LEN + 1);

  logic [1:0]     sync_q;
  logic           stable;
  logic [DBW-1:0] cnt;

  // sync_q[1] is the synchronised level; a change must persist DB_LEN cycles to be accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      press  <= 1'b0;
      if (sync_q[1] != stable) begin
        if (cnt == DBW'(DB_LEN - 1)) begin
          stable <= sync_q[1];
          cnt    <= '0;
          press  <= sync_q[1];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module count_ctrl #(
  parameter int TICK_DIV = 5_000_000,
  parameter int DB_LEN   = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_start_stop,
  input  logic btn_clear,
  output logic en,
  output logic clr,
  output logic running,
  output logic paused
);
  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state, state_nxt;
  logic [1:0]    btn, press;
  logic [PW-1:0] p;
  logic          wrap, clr_defer;

  assign btn = {btn_clear, btn_start_stop};

  for (genvar i = 0; i < 2; i++) begin : g_db
    count_ctrl_db #(.DB_LEN(DB_LEN)) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn[i]),
      .press(press[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (press[1]) begin
      state_nxt = IDLE;
    end else if (press[0]) begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign wrap = (state == RUN) && (p == PW'(TICK_DIV - 1));

  // A clear landing on a wrap lets the tick out first and slides clr one cycle
  // later, so en and clr are never high together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p         <= '0;
      en        <= 1'b0;
      clr       <= 1'b0;
      clr_defer <= 1'b0;
    end else begin
      case (state)
        RUN:     p <= wrap ? '0 : p + 1'b1;
        PAUSE:   p <= p;
        default: p <= '0;
      endcase
      en        <= wrap;
      clr       <= (press[1] && !wrap) || clr_defer;
      clr_defer <= press[1] && wrap;
    end
  end

  assign running = (state == RUN);
  assign paused  = (state == PAUSE);
endmodule
